// File: rtl/kvosic_counter_pkg.sv
// rtl/kvosic_counter_pkg.sv - shared bit indices and types for the up/down counter tile
package kvosic_counter_pkg;

   localparam int RUN        = 0;
   localparam int DIR        = 1;
   localparam int LOAD       = 2;
   localparam int CLR_STICKY = 3;
   localparam int CLR_COUNT  = 4;

   localparam int STICKY = 6;
   localparam int TC     = 7;

   localparam int MAX_WIDTH = 6;

   // Wide enough for PRESCALE up to 256 (counts 0..255).
   typedef logic [7:0] presc_cnt_t;

endpackage

// File: rtl/kvosic_prescaler.sv
// rtl/kvosic_prescaler.sv - enable prescaler, one tick every PRESCALE advancing cycles
module kvosic_prescaler
   import kvosic_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic advance,
   input  logic zero,
   output logic tick
);

   localparam presc_cnt_t LAST = presc_cnt_t'(PRESCALE - 1);

   presc_cnt_t presc_q, presc_d;

   assign tick = advance & (presc_q == LAST);

   always_comb begin
      presc_d = presc_q;
      if (zero) begin
         presc_d = '0;
      end else if (advance) begin
         presc_d = (presc_q == LAST) ? '0 : presc_q + presc_cnt_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/tt_um_kvosic_updown_counter.sv
// rtl/tt_um_kvosic_updown_counter.sv - modulo up/down counter tile; COUNTER_PRESCALE_EN builds the prescaler
module tt_um_kvosic_updown_counter
   import kvosic_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULO   = 2 ** WIDTH,
   parameter int PRESCALE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // One bit wider than the count so MODULO = 2**WIDTH still fits.
   localparam logic [WIDTH:0] MAX_C = (WIDTH + 1)'(MODULO - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             sticky_q, sticky_d;
   logic             tick, wrap;
   logic             run, dir, load, clr_sticky, clr_count;
   logic [WIDTH:0]   load_val;
   logic             unused_inputs;

   assign run        = ui_in[RUN];
   assign dir        = ui_in[DIR];
   assign load       = ui_in[LOAD];
   assign clr_sticky = ui_in[CLR_STICKY];
   assign clr_count  = ui_in[CLR_COUNT];
   assign load_val   = {1'b0, uio_in[WIDTH-1:0]};

   assign unused_inputs = &{1'b0, ui_in[7:5], uio_in};

`ifdef COUNTER_PRESCALE_EN
   kvosic_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (ena & run),
      .zero    (ena & (load | clr_count)),
      .tick    (tick)
   );
`else
   assign tick = ena & run;
`endif

   always_comb begin
      count_d  = count_q;
      tc_d     = tc_q;
      sticky_d = sticky_q;
      wrap     = 1'b0;
      if (ena) begin
         if (clr_count) begin
            count_d = '0;
         end else if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C[WIDTH-1:0] : uio_in[WIDTH-1:0];
         end else if (tick) begin
            if (dir) begin
               if ({1'b0, count_q} == MAX_C) begin
                  count_d = '0;
                  wrap    = 1'b1;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end else begin
               if (count_q == '0) begin
                  count_d = MAX_C[WIDTH-1:0];
                  wrap    = 1'b1;
               end else begin
                  count_d = count_q - WIDTH'(1);
               end
            end
         end
         // A wrap in the same cycle as clr_sticky keeps the flag set.
         if (clr_sticky) sticky_d = 1'b0;
         if (wrap)       sticky_d = 1'b1;
         tc_d = wrap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         tc_q     <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         tc_q     <= tc_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      uo_out             = '0;
      uo_out[WIDTH-1:0]  = count_q;
      uo_out[STICKY]     = sticky_q;
      uo_out[TC]         = tc_q;
   end

   assign uio_out = '0;
   assign uio_oe  = '0;

endmodule
